// File: rtl/ex_if.sv
// ID/EX-to-EX bundle: instruction fields in, results/redirect/stall out.
// Also carries the multiply/divide FSM state as a debug tap.
interface ex_if;
  // Handshake: EX is ready for a new instruction whenever stall_req_o is low; the
  // instruction on ex_* is consumed at the rising edge where stall_req_o = 0 and rdy = 1.
  logic [7:0]  ex_aluop;
  logic [31:0] ex_r1;
  logic [31:0] ex_r2;
  logic [4:0]  ex_w_addr;
  logic        ex_w_req;
  logic [31:0] ex_pc;
  logic [31:0] ex_offset;
  logic        ex_taken;

  logic [31:0] w_data_o;
  logic [4:0]  w_addr_o;
  logic        w_req_o;
  logic [7:0]  mem_aluop_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        b_flag_o;
  logic [31:0] b_target_o;
  logic        stall_req_o;
  logic [1:0]  md_state;

  modport master (
    output ex_aluop, ex_r1, ex_r2, ex_w_addr, ex_w_req, ex_pc, ex_offset, ex_taken,
    input  w_data_o, w_addr_o, w_req_o, mem_aluop_o, mem_addr_o, mem_data_o,
           b_flag_o, b_target_o, stall_req_o, md_state
  );

  modport slave (
    input  ex_aluop, ex_r1, ex_r2, ex_w_addr, ex_w_req, ex_pc, ex_offset, ex_taken,
    output w_data_o, w_addr_o, w_req_o, mem_aluop_o, mem_addr_o, mem_data_o,
           b_flag_o, b_target_o, stall_req_o, md_state
  );
endinterface

// File: rtl/ex.sv
// RV32IM execute stage: combinational ALU/branch/address path plus an
// iterative shift-add multiplier / restoring divider that stalls the pipeline.
module ex #(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  ex_if.slave bus
);

  localparam logic [7:0] EX_NOP    = 8'd0;
  localparam logic [7:0] EX_ADD    = 8'd1;
  localparam logic [7:0] EX_SUB    = 8'd2;
  localparam logic [7:0] EX_SLL    = 8'd3;
  localparam logic [7:0] EX_SLT    = 8'd4;
  localparam logic [7:0] EX_SLTU   = 8'd5;
  localparam logic [7:0] EX_XOR    = 8'd6;
  localparam logic [7:0] EX_SRL    = 8'd7;
  localparam logic [7:0] EX_SRA    = 8'd8;
  localparam logic [7:0] EX_OR     = 8'd9;
  localparam logic [7:0] EX_AND    = 8'd10;
  localparam logic [7:0] EX_LUI    = 8'd11;
  localparam logic [7:0] EX_AUIPC  = 8'd12;
  localparam logic [7:0] EX_JAL    = 8'd13;
  localparam logic [7:0] EX_JALR   = 8'd14;
  localparam logic [7:0] EX_BEQ    = 8'd15;
  localparam logic [7:0] EX_BNE    = 8'd16;
  localparam logic [7:0] EX_BLT    = 8'd17;
  localparam logic [7:0] EX_BGE    = 8'd18;
  localparam logic [7:0] EX_BLTU   = 8'd19;
  localparam logic [7:0] EX_BGEU   = 8'd20;
  localparam logic [7:0] EX_LB     = 8'd21;
  localparam logic [7:0] EX_LH     = 8'd22;
  localparam logic [7:0] EX_LW     = 8'd23;
  localparam logic [7:0] EX_LBU    = 8'd24;
  localparam logic [7:0] EX_LHU    = 8'd25;
  localparam logic [7:0] EX_SB     = 8'd26;
  localparam logic [7:0] EX_SH     = 8'd27;
  localparam logic [7:0] EX_SW     = 8'd28;
  localparam logic [7:0] EX_MUL    = 8'd29;
  localparam logic [7:0] EX_MULH   = 8'd30;
  localparam logic [7:0] EX_MULHSU = 8'd31;
  localparam logic [7:0] EX_MULHU  = 8'd32;
  localparam logic [7:0] EX_DIV    = 8'd33;
  localparam logic [7:0] EX_DIVU   = 8'd34;
  localparam logic [7:0] EX_REM    = 8'd35;
  localparam logic [7:0] EX_REMU   = 8'd36;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [63:0]       acc;
  logic [XLEN-1:0]   opnd_b;
  logic [7:0]        op_q;
  logic              neg_q;
  logic              neg_a_q;
  logic              div_zero_q;

  logic [7:0]        op;
  logic [XLEN-1:0]   r1, r2;
  logic              is_m;
  logic              a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]   abs_a, abs_b;

  assign op = bus.ex_aluop;
  assign r1 = bus.ex_r1;
  assign r2 = bus.ex_r2;
  assign is_m = (op >= EX_MUL) && (op <= EX_REMU);

  // MUL's low word is sign-agnostic, so it shares the signed path with MULH.
  assign a_signed = (op == EX_MUL) || (op == EX_MULH) || (op == EX_MULHSU) ||
                    (op == EX_DIV) || (op == EX_REM);
  assign b_signed = (op == EX_MUL) || (op == EX_MULH) || (op == EX_DIV) || (op == EX_REM);
  assign neg_a = a_signed & r1[XLEN-1];
  assign neg_b = b_signed & r2[XLEN-1];
  assign abs_a = neg_a ? -r1 : r1;
  assign abs_b = neg_b ? -r2 : r2;

  logic        q_is_div;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [32:0] div_diff;
  logic [63:0] step_acc;

  assign q_is_div  = (op_q >= EX_DIV);
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
  assign div_shift = {acc[63:32], acc[31]};
  assign div_ge    = div_shift >= {1'b0, opnd_b};
  assign div_diff  = div_shift - {1'b0, opnd_b};
  assign step_acc  = q_is_div ? {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge}
                              : {mul_sum, acc[31:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd_b     <= '0;
      op_q       <= EX_NOP;
      neg_q      <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          if (is_m) begin
            acc        <= {32'd0, abs_a};
            opnd_b     <= abs_b;
            op_q       <= op;
            neg_q      <= neg_a ^ neg_b;
            neg_a_q    <= neg_a;
            div_zero_q <= (r2 == '0);
            cnt        <= '0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc <= step_acc;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MD_ITERS - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sign correction; the 0x80000000 / -1 case falls out of the magnitude path naturally.
  logic [63:0]     prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, md_result;

  always_comb begin
    prod_fix  = neg_q ? -acc : acc;
    quot_fix  = div_zero_q ? '1 : (neg_q ? -acc[31:0] : acc[31:0]);
    rem_fix   = neg_a_q ? -acc[63:32] : acc[63:32];
    md_result = '0;
    case (op_q)
      EX_MUL:                          md_result = prod_fix[31:0];
      EX_MULH, EX_MULHSU, EX_MULHU:    md_result = prod_fix[63:32];
      EX_DIV, EX_DIVU:                 md_result = quot_fix;
      EX_REM, EX_REMU:                 md_result = rem_fix;
      default:                         md_result = '0;
    endcase
  end

  logic [XLEN-1:0] pc4, br_tgt, jalr_sum, ls_addr;
  logic            br_cond;
  logic [XLEN-1:0] w_data;
  logic            w_req, b_flag, stall;
  logic [7:0]      mem_aluop;
  logic [XLEN-1:0] mem_addr, mem_data, b_target;

  assign pc4      = bus.ex_pc + 32'd4;
  assign br_tgt   = bus.ex_pc + bus.ex_offset;
  assign jalr_sum = r1 + bus.ex_offset;
  assign ls_addr  = r1 + bus.ex_offset;

  always_comb begin
    w_data    = '0;
    w_req     = bus.ex_w_req;
    mem_aluop = EX_NOP;
    mem_addr  = '0;
    mem_data  = '0;
    b_flag    = 1'b0;
    b_target  = '0;
    stall     = 1'b0;
    br_cond   = 1'b0;
    case (op)
      EX_ADD:   w_data = r1 + r2;
      EX_SUB:   w_data = r1 - r2;
      EX_SLL:   w_data = r1 << r2[4:0];
      EX_SLT:   w_data = {31'd0, $signed(r1) < $signed(r2)};
      EX_SLTU:  w_data = {31'd0, r1 < r2};
      EX_XOR:   w_data = r1 ^ r2;
      EX_SRL:   w_data = r1 >> r2[4:0];
      EX_SRA:   w_data = $signed(r1) >>> r2[4:0];
      EX_OR:    w_data = r1 | r2;
      EX_AND:   w_data = r1 & r2;
      // r2 carries the already-shifted U-type immediate.
      EX_LUI:   w_data = r2;
      EX_AUIPC: w_data = bus.ex_pc + r2;
      EX_JAL: begin
        w_data   = pc4;
        b_flag   = ~bus.ex_taken;
        b_target = br_tgt;
      end
      EX_JALR: begin
        w_data   = pc4;
        b_flag   = 1'b1;
        b_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      EX_BEQ, EX_BNE, EX_BLT, EX_BGE, EX_BLTU, EX_BGEU: begin
        case (op)
          EX_BEQ:  br_cond = (r1 == r2);
          EX_BNE:  br_cond = (r1 != r2);
          EX_BLT:  br_cond = ($signed(r1) < $signed(r2));
          EX_BGE:  br_cond = ($signed(r1) >= $signed(r2));
          EX_BLTU: br_cond = (r1 < r2);
          default: br_cond = (r1 >= r2);
        endcase
        b_flag   = br_cond ^ bus.ex_taken;
        b_target = br_cond ? br_tgt : pc4;
      end
      EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU: begin
        mem_aluop = op;
        mem_addr  = ls_addr;
      end
      EX_SB, EX_SH, EX_SW: begin
        mem_aluop = op;
        mem_addr  = ls_addr;
        mem_data  = r2;
      end
      default: w_data = '0;
    endcase

    if (state == S_DONE) begin
      w_data = md_result;
      w_req  = bus.ex_w_req;
      stall  = 1'b0;
      b_flag = 1'b0;
    end else if ((state == S_BUSY) || is_m) begin
      w_data = '0;
      w_req  = 1'b0;
      stall  = 1'b1;
      b_flag = 1'b0;
    end

    // A stage under reset requests neither a write nor a stall, whatever sits in ID/EX.
    if (rst) begin
      w_req = 1'b0;
      stall = 1'b0;
    end
  end

  assign bus.w_data_o    = w_data;
  assign bus.w_addr_o    = bus.ex_w_addr;
  assign bus.w_req_o     = w_req;
  assign bus.mem_aluop_o = mem_aluop;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_data_o  = mem_data;
  assign bus.b_flag_o    = b_flag;
  assign bus.b_target_o  = b_target;
  assign bus.stall_req_o = stall;
  assign bus.md_state    = state;

endmodule

// File: tb/tb_ex.sv
// Bench for the execute stage: directed branch/ALU/M-op cases, reset and rdy
// interruptions, and randomized ALU and multiply/divide traffic against a scoreboard.
module tb_ex;

  localparam logic [7:0] EX_NOP = 8'd0, EX_ADD = 8'd1, EX_SUB = 8'd2, EX_SLL = 8'd3;
  localparam logic [7:0] EX_SLT = 8'd4, EX_SLTU = 8'd5, EX_XOR = 8'd6, EX_SRL = 8'd7;
  localparam logic [7:0] EX_SRA = 8'd8, EX_OR = 8'd9, EX_AND = 8'd10, EX_LUI = 8'd11;
  localparam logic [7:0] EX_AUIPC = 8'd12, EX_JAL = 8'd13, EX_JALR = 8'd14, EX_BEQ = 8'd15;
  localparam logic [7:0] EX_BNE = 8'd16, EX_BLT = 8'd17, EX_LW = 8'd23, EX_SW = 8'd28;
  localparam logic [7:0] EX_MUL = 8'd29, EX_MULH = 8'd30, EX_MULHSU = 8'd31, EX_MULHU = 8'd32;
  localparam logic [7:0] EX_DIV = 8'd33, EX_DIVU = 8'd34, EX_REM = 8'd35, EX_REMU = 8'd36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  ex_if bus();

  ex dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] off, input logic taken);
    bus.ex_aluop  = op;
    bus.ex_r1     = a;
    bus.ex_r2     = b;
    bus.ex_pc     = pc;
    bus.ex_offset = off;
    bus.ex_taken  = taken;
    bus.ex_w_addr = (op == EX_NOP) ? 5'd0 : 5'd7;
    bus.ex_w_req  = (op != EX_NOP);
  endtask

  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      EX_ADD:   return a + b;
      EX_SUB:   return a - b;
      EX_SLL:   return a << b[4:0];
      EX_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      EX_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      EX_XOR:   return a ^ b;
      EX_SRL:   return a >> b[4:0];
      EX_SRA:   return 32'(sa >>> b[4:0]);
      EX_OR:    return a | b;
      EX_AND:   return a & b;
      EX_LUI:   return b;
      EX_AUIPC: return pc + b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_md(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      EX_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      EX_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      EX_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      EX_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      EX_DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      EX_REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      EX_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      EX_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  task automatic run_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    @(negedge clk);
    drive(op, a, b, 32'h0000_0400, 32'd0, 1'b0);
    exp_q.push_back(model_alu(op, a, b, 32'h0000_0400));
    #1;
    check(tag, bus.w_data_o, exp_q.pop_front());
    check({tag, "_stall"}, {31'd0, bus.stall_req_o}, 32'd0);
  endtask

  // gap > 0 drops rdy for that many cycles starting at T10.
  task automatic run_mop(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int gap, input string tag);
    int n;
    @(negedge clk);
    drive(op, a, b, 32'd0, 32'd0, 1'b0);
    exp_q.push_back(model_md(op, a, b));
    #1;
    check({tag, "_stall_t0"}, {31'd0, bus.stall_req_o}, 32'd1);
    n = 0;
    while (bus.stall_req_o && n < 100) begin
      if (gap > 0 && n == 10) rdy = 1'b0;
      if (gap > 0 && n == 10 + gap) rdy = 1'b1;
      @(negedge clk);
      #1;
      n++;
      if (n == 1) check({tag, "_wreq_busy"}, {31'd0, bus.w_req_o}, 32'd0);
    end
    rdy = 1'b1;
    check({tag, "_latency"}, 32'(n), 32'(33 + gap));
    check({tag, "_wreq"}, {31'd0, bus.w_req_o}, 32'd1);
    check({tag, "_bflag"}, {31'd0, bus.b_flag_o}, 32'd0);
    check(tag, bus.w_data_o, exp_q.pop_front());
    drive(EX_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  logic [7:0] alu_ops[12] = '{EX_ADD, EX_SUB, EX_SLL, EX_SLT, EX_SLTU, EX_XOR,
                              EX_SRL, EX_SRA, EX_OR, EX_AND, EX_LUI, EX_AUIPC};
  logic [7:0] md_ops[8]   = '{EX_MUL, EX_MULH, EX_MULHSU, EX_MULHU,
                              EX_DIV, EX_DIVU, EX_REM, EX_REMU};

  initial begin
    drive(EX_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_w_data", bus.w_data_o, 32'd0);
    check("rst_w_addr", {27'd0, bus.w_addr_o}, 32'd0);
    check("rst_w_req", {31'd0, bus.w_req_o}, 32'd0);
    check("rst_mem_op", {24'd0, bus.mem_aluop_o}, {24'd0, EX_NOP});
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_mem_data", bus.mem_data_o, 32'd0);
    check("rst_b_flag", {31'd0, bus.b_flag_o}, 32'd0);
    check("rst_b_target", bus.b_target_o, 32'd0);
    check("rst_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("rst_state", {30'd0, bus.md_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_alu(EX_ADD, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    check("add_bflag", {31'd0, bus.b_flag_o}, 32'd0);
    check("add_wreq", {31'd0, bus.w_req_o}, 32'd1);
    check("add_waddr", {27'd0, bus.w_addr_o}, 32'd7);
    run_alu(EX_SLT, 32'hFFFF_FFFF, 32'd1, "slt_neg");
    run_alu(EX_SLTU, 32'hFFFF_FFFF, 32'd1, "sltu_big");
    run_alu(EX_SRA, 32'h8000_0000, 32'h0000_0024, "sra_r2lo");

    @(negedge clk);
    drive(EX_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    #1;
    check("beq_nt_flag", {31'd0, bus.b_flag_o}, 32'd1);
    check("beq_nt_target", bus.b_target_o, 32'h120);
    bus.ex_taken = 1'b1;
    #1;
    check("beq_t_flag", {31'd0, bus.b_flag_o}, 32'd0);
    drive(EX_BNE, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
    #1;
    check("bne_flag", {31'd0, bus.b_flag_o}, 32'd1);
    check("bne_target", bus.b_target_o, 32'h104);
    drive(EX_BLT, 32'hFFFF_FFFE, 32'd3, 32'h200, 32'hFFFF_FFF0, 1'b0);
    #1;
    check("blt_target", bus.b_target_o, 32'h1F0);
    drive(EX_JAL, 32'd0, 32'd0, 32'h300, 32'h40, 1'b1);
    #1;
    check("jal_flag", {31'd0, bus.b_flag_o}, 32'd0);
    check("jal_link", bus.w_data_o, 32'h304);
    drive(EX_JALR, 32'h201, 32'd4, 32'h300, 32'd4, 1'b1);
    #1;
    check("jalr_flag", {31'd0, bus.b_flag_o}, 32'd1);
    check("jalr_target", bus.b_target_o, 32'h204);
    drive(EX_SW, 32'h1000, 32'hDEAD_BEEF, 32'h0, 32'h8, 1'b0);
    #1;
    check("sw_addr", bus.mem_addr_o, 32'h1008);
    check("sw_data", bus.mem_data_o, 32'hDEAD_BEEF);
    check("sw_op", {24'd0, bus.mem_aluop_o}, {24'd0, EX_SW});
    drive(EX_LW, 32'h1000, 32'h1234, 32'h0, 32'hFFFF_FFFC, 1'b0);
    #1;
    check("lw_addr", bus.mem_addr_o, 32'h0FFC);
    check("lw_data", bus.mem_data_o, 32'd0);

    run_mop(EX_DIV, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
    run_mop(EX_REM, 32'd7, 32'hFFFF_FFFE, 0, "rem_7_m2");
    run_mop(EX_DIVU, 32'd9, 32'd0, 0, "divu_by0");
    run_mop(EX_REM, 32'hFFFF_FFFB, 32'd0, 0, "rem_by0");
    run_mop(EX_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_mop(EX_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_mop(EX_MULH, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
    run_mop(EX_MULHSU, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu_m1");
    run_mop(EX_MUL, 32'hFFFF_FFFD, 32'd7, 0, "mul_neg");
    run_mop(EX_DIVU, 32'd100, 32'd7, 5, "divu_rdy_gap");

    @(negedge clk);
    drive(EX_DIV, 32'd50, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    check("abort_busy", {31'd0, bus.stall_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("abort_wreq", {31'd0, bus.w_req_o}, 32'd0);
    check("abort_state", {30'd0, bus.md_state}, 32'd0);
    drive(EX_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_mop(EX_DIV, 32'd50, 32'd3, 0, "div_after_rst");

    for (int i = 0; i < 40; i++) begin
      run_alu(alu_ops[$urandom_range(0, 11)], $urandom, $urandom, "rand_alu");
    end
    for (int i = 0; i < 12; i++) begin
      logic [31:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_mop(md_ops[$urandom_range(0, 7)], $urandom, rb, 0, "rand_md");
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex.md
# ex

Execute stage of the RV32IM pipeline. It consumes the instruction held in the ID/EX register and computes the write-back value, memory address and store data. It resolves branches and jumps against the front-end prediction. RV32M multiply/divide runs on a 32-iteration shift/subtract engine, and the stage stalls the pipeline (via ctrl) while that engine is busy.

## Interface
- XLEN, 32, datapath width (fixed).
- MD_ITERS, 32, iterations per multiply/divide.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- ex_aluop  in  AluOpBus  operation code from ID/EX (shared op defines; EX_NOP = bubble).
- ex_r1, ex_r2  in  32  source operands (rs1, rs2 or immediate).
- ex_w_addr  in  5  destination register.
- ex_w_req  in  1  destination write request.
- ex_pc  in  32  instruction PC.
- ex_offset  in  32  branch/jump/store offset.
- ex_taken  in  1  front-end predicted taken.
- w_data_o  out  32  result; also the forwarding source.
- w_addr_o  out  5  destination register.
- w_req_o  out  1  write request.
- mem_aluop_o  out  AluOpBus  load/store op passed to EX/MEM; EX_NOP otherwise.
- mem_addr_o  out  32  r1 + offset for loads/stores.
- mem_data_o  out  32  store data (r2).
- b_flag_o  out  1  misprediction; flush IF/ID and ID/EX.
- b_target_o  out  32  correct next PC when b_flag_o = 1.
- stall_req_o  out  1  request to ctrl to hold PC, IF/ID and ID/EX.

## Operation
- Single-cycle ops (RV32I ALU, LUI/AUIPC, loads/stores, branches, JAL/JALR):
  - All outputs are combinational from the inputs.
  - JAL/JALR write pc+4.
  - Shifts use r2[4:0].
  - SLT is signed; SLTU is unsigned.
- Branch resolution:
  - actual target = pc+offset for branches and JAL; (r1+offset) & ~1 for JALR.
  - Not-taken path is pc+4.
  - b_flag_o = 1 when actual taken ≠ ex_taken. JALR always flags.
  - b_target_o = actual taken ? target : pc+4.
- M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU):
  - Handled by an FSM with states IDLE, BUSY, DONE.
  - IDLE, M op present: capture |operands|, sign info and op; counter = 0; stall_req_o = 1; go to BUSY.
  - BUSY: one iteration per cycle. Multiply is shift-add into a 64-bit product; divide is restoring, 1 quotient bit per cycle. stall_req_o = 1. When the counter reaches MD_ITERS-1, go to DONE.
  - DONE: apply sign correction; w_data_o = result; w_req_o = ex_w_req; stall_req_o = 0. Return unconditionally to IDLE on the next edge.
  - Output gating: w_req_o = 0 while in IDLE (M op) or BUSY. b_flag_o = 0 throughout.
- Result selection:
  - MUL takes the low product word; MULH/MULHSU/MULHU take the high word.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - Special cases keep the full latency.
- rdy = 0: FSM, counter and operand registers hold; outputs reflect the held state.
- rst: FSM → IDLE, counter and operand registers → 0, including mid-operation. The partial result is discarded.
- Reset values of outputs (during rst with bubble inputs): w_data_o = 0, w_addr_o = 0, w_req_o = 0, mem_aluop_o = EX_NOP, mem_addr_o = 0, mem_data_o = 0, b_flag_o = 0, b_target_o = 0, stall_req_o = 0.

## Timing
- Single-cycle ops:
  - Latency 0 (combinational); EX/MEM captures the result on the next edge.
  - b_flag_o is valid in the same cycle; ID/EX inserts a bubble on the next edge.
- M op entering EX at cycle T0:
  - stall_req_o is high in T0..T32 (33 cycles).
  - Result is valid in T33; ID/EX loads the next instruction at the end of T33.
  - Total occupancy: 34 cycles, excluding rdy-low cycles.
- Back-to-back M ops: the second is seen in IDLE at T34 and restarts with no gap.
- ctrl stall from downstream while in DONE: the FSM still returns to IDLE. Because ID/EX still holds the same M op, it reissues. ctrl guarantees MEM never stalls EX; this is a documented restriction.

## Test plan
- ADD r1=0x7FFFFFFF, r2=1 → w_data_o=0x80000000, stall_req_o=0, b_flag_o=0, same cycle.
- BEQ r1=r2=5, pc=0x100, offset=0x20, ex_taken=0 → b_flag_o=1, b_target_o=0x120. With ex_taken=1 → b_flag_o=0.
- DIV r1=7, r2=-2 at T0 → stall_req_o high T0..T32; T33 w_data_o=0xFFFFFFFD. REM variant → 1.
- DIVU r1=9, r2=0 → 0xFFFFFFFF. REM r1=0x80000000, r2=-1 → 0. DIV of the same operands → 0x80000000.
- MULH r1=0x80000000, r2=0x80000000 → 0x40000000. MULHSU r1=-1, r2=2 → 0xFFFFFFFF.
- DIV started, rst pulsed at T10 → stall_req_o=0 and w_req_o=0 immediately. After release, a fresh DIV completes 34 cycles later. rdy low 5 cycles mid-BUSY → completion shifts to T38.
